multi_channel_change_reporter: RTL and testbench

Parametrised generalisation of the LED/element change-to-UART reporter. It watches CHANNEL_COUNT input words of CHANNEL_WIDTH bits and detects when any word differs from the value last reported for it. For each change it emits an ASCII frame (channel letter, colon, hex value, CR, LF) one byte at a time over a valid/ready handshake. It sits between the board input sampling logic and uart_tx_fifo, replacing the fixed two-field reporter.

---
 rtl/multi_channel_change_reporter.sv | 143 ++++++++++++++
 tb/tb_multi_channel_change_reporter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_change_reporter.sv
// Watches CHANNEL_COUNT words and, for each word that changed since it was last
// reported, streams an ASCII frame "<letter>:<hex digits>\r\n" over valid/ready.
module multi_channel_change_reporter #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_COUNT = 4,
    parameter int CHANNEL_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   ena,
    input  logic [CHANNEL_COUNT*CHANNEL_WIDTH-1:0] channel_data,
    input  logic                                   report_all,
    input  logic                                   tx_ready,
    output logic [DATA_WIDTH-1:0]                  output_data,
    output logic                                   output_valid,
    output logic                                   busy
);

    localparam int ND    = (CHANNEL_WIDTH + 3) / 4;
    localparam int SEL_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int IDX_W = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ID    = 3'd1;
    localparam logic [2:0] S_SEP   = 3'd2;
    localparam logic [2:0] S_DIGIT = 3'd3;
    localparam logic [2:0] S_CR    = 3'd4;
    localparam logic [2:0] S_LF    = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [SEL_W-1:0]         last_served_q, last_served_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [ND*4-1:0]          snap_q, snap_d;
    logic [CHANNEL_COUNT-1:0] force_q, force_d;
    logic [CHANNEL_WIDTH-1:0] last_rep_q [CHANNEL_COUNT];
    logic [CHANNEL_WIDTH-1:0] chan       [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] pending;
    logic [SEL_W-1:0]         pick;
    logic [SEL_W-1:0]         cand;
    logic                     found;
    logic                     start;
    logic                     xfer;
    logic [3:0]               nib;
    logic [7:0]               hex_char;
    logic [7:0]               out_byte;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
            assign chan[gi]    = channel_data[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            assign pending[gi] = (chan[gi] != last_rep_q[gi]) | force_q[gi];
            // A report_all arriving with this channel's selection keeps the force set.
            assign force_d[gi] = (ena & report_all) |
                                 (force_q[gi] & ~(start && (pick == SEL_W'(gi))));
        end
    endgenerate

    // Round-robin search starting just after the most recently served channel.
    always_comb begin
        found = 1'b0;
        pick  = last_served_q;
        cand  = '0;
        for (int k = 1; k <= CHANNEL_COUNT; k++) begin
            cand = SEL_W'((int'(last_served_q) + k) % CHANNEL_COUNT);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign start = ena && (state_q == S_IDLE) && found;
    assign xfer  = ena && output_valid && tx_ready;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_served_d = last_served_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        if (start) begin
            state_d       = S_ID;
            sel_d         = pick;
            last_served_d = pick;
            idx_d         = IDX_W'(ND - 1);
            snap_d        = '0;
            snap_d[CHANNEL_WIDTH-1:0] = chan[pick];
        end else if (xfer) begin
            case (state_q)
                S_ID:    state_d = S_SEP;
                S_SEP:   state_d = S_DIGIT;
                S_DIGIT: begin
                    if (idx_q == '0) state_d = S_CR;
                    else             idx_d   = idx_q - 1'b1;
                end
                S_CR:    state_d = S_LF;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            last_served_q <= SEL_W'(CHANNEL_COUNT - 1);
            idx_q         <= '0;
            snap_q        <= '0;
            force_q       <= '0;
            for (int i = 0; i < CHANNEL_COUNT; i++) last_rep_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_served_q <= last_served_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            force_q       <= force_d;
            if (start) last_rep_q[pick] <= chan[pick];
        end
    end

    assign nib      = snap_q[{idx_q, 2'b00} +: 4];
    assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

    // Output is decoded from registered state only, so it freezes with ena low.
    always_comb begin
        out_byte = 8'h00;
        case (state_q)
            S_ID:    out_byte = 8'h41 + {{(8-SEL_W){1'b0}}, sel_q};
            S_SEP:   out_byte = 8'h3A;
            S_DIGIT: out_byte = hex_char;
            S_CR:    out_byte = 8'h0D;
            S_LF:    out_byte = 8'h0A;
            default: out_byte = 8'h00;
        endcase
    end

    assign output_data  = out_byte;
    assign output_valid = (state_q != S_IDLE);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_channel_change_reporter.sv
// Bench for multi_channel_change_reporter: directed scenarios plus a randomized run,
// all checked against a frame-level queue model of the byte stream.
module tb_multi_channel_change_reporter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena;
    logic [15:0] ch [4];
    logic [63:0] channel_data;
    logic        report_all;
    logic        tx_ready;
    logic [7:0]  output_data;
    logic        output_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // model state
    logic [15:0] m_last [4];
    logic [3:0]  m_force;
    int          m_last_served;
    logic [7:0]  mq [$];
    logic [7:0]  got [$];
    logic        exp_v;
    logic [7:0]  exp_d;

    assign channel_data = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    multi_channel_change_reporter #(
        .DATA_WIDTH(8), .CHANNEL_COUNT(4), .CHANNEL_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .channel_data(channel_data),
        .report_all(report_all), .tx_ready(tx_ready), .output_data(output_data),
        .output_valid(output_valid), .busy(busy)
    );

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    function automatic string q_hex();
        string r = "";
        foreach (got[i]) r = {r, $sformatf("%02h ", got[i])};
        return r;
    endfunction

    function automatic string s_hex(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_last[i] = '0;
        m_force = '0;
        m_last_served = 3;
        mq.delete();
    endtask

    // One clock edge of the abstract model: a frame is a queue of bytes; a new
    // frame is chosen only on an edge where the queue is already empty.
    task automatic model_step();
        bit found;
        int sel;
        if (!ena) return;
        if (mq.size() != 0) begin
            if (tx_ready) void'(mq.pop_front());
        end else begin
            found = 0;
            sel   = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last_served + k) % 4;
                if (!found && ((ch[c] != m_last[c]) || m_force[c])) begin
                    found = 1;
                    sel   = c;
                end
            end
            if (found) begin
                mq.push_back(8'h41 + 8'(sel));
                mq.push_back(8'h3A);
                for (int d = 3; d >= 0; d--) mq.push_back(hexc(ch[sel][d*4 +: 4]));
                mq.push_back(8'h0D);
                mq.push_back(8'h0A);
                m_last[sel]   = ch[sel];
                m_force[sel]  = 1'b0;
                m_last_served = sel;
            end
        end
        if (report_all) m_force = 4'hF;
    endtask

    task automatic tick();
        if (reset_n && output_valid && tx_ready && ena) got.push_back(output_data);
        if (reset_n) model_step();
        else         model_reset();
        @(posedge clk);
        #1;
        exp_v = (mq.size() != 0);
        exp_d = exp_v ? mq[0] : 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ena = 1'b1; report_all = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) ch[i] = '0;
        model_reset();
        #2;
        total++;
        if (output_valid !== 1'b0 || busy !== 1'b0 || output_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: valid=%b busy=%b data=%h required 0 0 00",
                     output_valid, busy, output_data);
        end
        tick(); tick();
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            total++;
            if (output_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: valid=%b busy=%b required 0 0",
                         n, output_valid, busy);
            end
        end
    endtask

    task automatic test_single_frame();
        string exp_s = "A:F0FF\r\n";
        ch[0] = 16'hF0FF;
        for (int n = 0; n < 10; n++) begin
            tick();
            total++;
            if (n < 8) begin
                if (output_valid !== 1'b1 || output_data !== exp_s[n]) begin
                    bad++;
                    $display("FAIL single_byte%0d: valid=%b data=%h required 1 %h",
                             n, output_valid, output_data, exp_s[n]);
                end
            end else if (output_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL single_gap cyc%0d: valid=%b busy=%b required 0 0",
                         n, output_valid, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       pv;
        logic [7:0] pd;
        logic       stall;
        ch[0] = 16'h0000;
        for (int n = 0; n < 12; n++) tick();
        got.delete();
        ch[0] = 16'hF0FF;
        for (int n = 0; n < 40; n++) begin
            tx_ready = (n % 3 == 2);
            pv = output_valid; pd = output_data;
            stall = output_valid && !(tx_ready && ena);
            tick();
            total++;
            if (output_valid !== exp_v || busy !== exp_v ||
                (exp_v && output_data !== exp_d) || (stall && output_data !== pd)) begin
                bad++;
                $display("FAIL bp_cycle%0d: valid=%b data=%h prev=%b/%h required %b %h",
                         n, output_valid, output_data, pv, pd, exp_v, exp_d);
            end
        end
        tx_ready = 1'b1;
        total++;
        if (q_hex() != s_hex("A:F0FF\r\n")) begin
            bad++;
            $display("FAIL bp_stream: got %s required %s", q_hex(), s_hex("A:F0FF\r\n"));
        end
    endtask

    task automatic test_two_channels();
        string exp_s = "B:1234\r\nD:00AB\r\n";
        got.delete();
        ch[1] = 16'h1234;
        ch[3] = 16'h00AB;
        for (int n = 0; n < 25; n++) begin
            tick();
            total++;
            if (output_valid !== exp_v || (exp_v && output_data !== exp_d)) begin
                bad++;
                $display("FAIL two_cycle%0d: valid=%b data=%h required %b %h",
                         n, output_valid, output_data, exp_v, exp_d);
            end
        end
        total++;
        if (q_hex() != s_hex(exp_s)) begin
            bad++;
            $display("FAIL two_stream: got %s required %s", q_hex(), s_hex(exp_s));
        end
    endtask

    task automatic test_midframe_change();
        got.delete();
        ch[2] = 16'hAFCD;
        tick(); tick(); tick();
        ch[2] = 16'hAACD;
        for (int n = 0; n < 25; n++) tick();
        total++;
        if (q_hex() != s_hex("C:AFCD\r\nC:AACD\r\n")) begin
            bad++;
            $display("FAIL mid_change: got %s required %s", q_hex(), s_hex("C:AFCD\r\nC:AACD\r\n"));
        end
        got.delete();
        ch[2] = 16'hAFCD;
        tick(); tick(); tick();
        ch[2] = 16'h0000;
        tick();
        ch[2] = 16'hAFCD;
        for (int n = 0; n < 25; n++) tick();
        total++;
        if (q_hex() != s_hex("C:AFCD\r\n")) begin
            bad++;
            $display("FAIL mid_restore: got %s required %s", q_hex(), s_hex("C:AFCD\r\n"));
        end
    endtask

    task automatic test_report_all();
        string exp_s = "A:0001\r\nB:0002\r\nC:0003\r\nD:0004\r\n";
        bit seen;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ch[0] = 16'd1; ch[1] = 16'd2; ch[2] = 16'd3; ch[3] = 16'd4;
        for (int n = 0; n < 45; n++) tick();
        got.delete();
        report_all = 1'b1;
        tick();
        report_all = 1'b0;
        for (int n = 0; n < 45; n++) begin
            tick();
            total++;
            if (output_valid !== exp_v || (exp_v && output_data !== exp_d)) begin
                bad++;
                $display("FAIL rall_cycle%0d: valid=%b data=%h required %b %h",
                         n, output_valid, output_data, exp_v, exp_d);
            end
        end
        total++;
        if (q_hex() != s_hex(exp_s)) begin
            bad++;
            $display("FAIL rall_stream: got %s required %s", q_hex(), s_hex(exp_s));
        end
        // abandon the B frame with reset
        report_all = 1'b1;
        tick();
        report_all = 1'b0;
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            tick();
            if (output_valid && output_data == 8'h42) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rall_b_start: B frame not seen within 30 cycles, required one");
        end
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (output_valid !== 1'b0 || busy !== 1'b0 || output_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_midframe: valid=%b busy=%b data=%h required 0 0 00",
                     output_valid, busy, output_data);
        end
        for (int i = 0; i < 4; i++) ch[i] = '0;
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            total++;
            if (output_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset cyc%0d: valid=%b busy=%b required 0 0",
                         n, output_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic       pv;
        logic [7:0] pd;
        logic       stall;
        got.delete();
        for (int n = 0; n < 1500; n++) begin
            ena        = ($urandom_range(0, 9) != 0);
            tx_ready   = $urandom_range(0, 1);
            report_all = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) ch[$urandom_range(0, 3)] = 16'($urandom);
            pv = output_valid; pd = output_data;
            stall = output_valid && !(tx_ready && ena);
            tick();
            total++;
            if (output_valid !== exp_v || busy !== exp_v ||
                (exp_v && output_data !== exp_d) || (stall && output_data !== pd)) begin
                bad++;
                $display("FAIL rand_cycle%0d: valid=%b busy=%b data=%h prev=%b/%h required %b %h",
                         n, output_valid, busy, output_data, pv, pd, exp_v, exp_d);
            end
        end
        ena = 1'b1; tx_ready = 1'b1; report_all = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_two_channels();
        test_midframe_change();
        test_report_all();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
